// File: rtl/common.sv
// Shared memory-side types for the cache hierarchy: physical line pointers,
// cache lines, and the arbiter's owner/state enums.
package common;

   localparam int PPTR_W     = 32;
   localparam int LINE_BYTES = 64;
   localparam int LINE_W     = LINE_BYTES * 8;
   localparam int OFFSET_W   = $clog2(LINE_BYTES);

   typedef logic [PPTR_W-1:0]   pptr_t;
   typedef logic [LINE_W-1:0]   cacheline_t;
   typedef logic [OFFSET_W-1:0] byte_offset_t;

   typedef enum logic {
      OWNER_IC = 1'b0,
      OWNER_DC = 1'b1
   } arb_owner_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic       wen;
      pptr_t      addr;
      cacheline_t line;
   } dc_entry_t;

   // Round-robin pick: with both queues pending, serve whoever did not go last.
   function automatic arb_owner_t next_owner(input logic ic_has, input logic dc_has,
                                             input arb_owner_t last);
      arb_owner_t pick;
      if (ic_has && dc_has) begin
         pick = (last == OWNER_IC) ? OWNER_DC : OWNER_IC;
      end else if (dc_has) begin
         pick = OWNER_DC;
      end else begin
         pick = OWNER_IC;
      end
      return pick;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache request, refill delivery and memory handshake signals.
// slave = the arbiter, master = the caches/memory environment driving it.
interface mem_arbiter_if;
   import common::*;

   logic       ic_req_ren;
   pptr_t      ic_req_addr;
   logic       dc_req_ren;
   logic       dc_req_wen;
   pptr_t      dc_req_addr;
   cacheline_t dc_req_cacheline;

   logic       ic_rec_en;
   pptr_t      ic_rec_addr;
   cacheline_t ic_rec_cacheline;
   logic       dc_rec_en;
   pptr_t      dc_rec_addr;
   cacheline_t dc_rec_cacheline;

   logic       mem_req_valid;
   logic       mem_req_ready;
   logic       mem_req_wen;
   pptr_t      mem_req_addr;
   cacheline_t mem_req_cacheline;

   logic       mem_rsp_valid;
   pptr_t      mem_rsp_addr;
   cacheline_t mem_rsp_cacheline;

   logic       ic_overflow;
   logic       dc_overflow;

   modport slave (
      input  ic_req_ren, ic_req_addr, dc_req_ren, dc_req_wen, dc_req_addr, dc_req_cacheline,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_addr, mem_rsp_cacheline,
      output ic_rec_en, ic_rec_addr, ic_rec_cacheline,
      output dc_rec_en, dc_rec_addr, dc_rec_cacheline,
      output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_cacheline,
      output ic_overflow, dc_overflow
   );

   modport master (
      output ic_req_ren, ic_req_addr, dc_req_ren, dc_req_wen, dc_req_addr, dc_req_cacheline,
      output mem_req_ready, mem_rsp_valid, mem_rsp_addr, mem_rsp_cacheline,
      input  ic_rec_en, ic_rec_addr, ic_rec_cacheline,
      input  dc_rec_en, dc_rec_addr, dc_rec_cacheline,
      input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_cacheline,
      input  ic_overflow, dc_overflow
   );

endinterface

// File: rtl/req_fifo.sv
// Request queue: DEPTH entries of payload type T, head visible combinationally,
// sticky overflow when a push is refused.
module req_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic empty,
   output logic full,
   output logic overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   T              mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          overflow_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign empty    = (count_r == {CW{1'b0}});
   assign full     = (count_r == CW'(DEPTH));
   assign head     = mem_r[rd_ptr_r];
   assign overflow = overflow_r;

   // A pop in the same cycle frees the slot, so a full queue still accepts.
   assign push_ok_s = push && (!full || pop) && !rst;
   assign pop_ok_s  = pop && !empty;

   // Storage array; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer, occupancy and sticky overflow bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         overflow_r <= overflow_r | (push && !push_ok_s);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache line requests onto a single memory port with
// one outstanding transaction, and routes read responses back to the owner.
module mem_arbiter
   import common::*;
#(
   parameter int QDEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   pptr_t      ic_head_s;
   dc_entry_t  dc_head_s;
   dc_entry_t  dc_push_s;
   logic       ic_empty_s, ic_full_s, ic_ovf_s;
   logic       dc_empty_s, dc_full_s, dc_ovf_s;
   logic       grant_valid_s;
   arb_owner_t grant_owner_s;
   logic       pop_ic_s, pop_dc_s;
   logic       rsp_match_s;

   arb_state_t state_r;
   arb_owner_t owner_r;
   arb_owner_t last_grant_r;
   logic       mem_req_valid_r;
   logic       txn_wen_r;
   pptr_t      txn_addr_r;
   cacheline_t txn_line_r;

   assign dc_push_s = '{wen: bus.dc_req_wen, addr: bus.dc_req_addr, line: bus.dc_req_cacheline};

   req_fifo #(.DEPTH(QDEPTH), .T(pptr_t)) u_ic_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.ic_req_ren),
      .push_data (bus.ic_req_addr),
      .pop       (pop_ic_s),
      .head      (ic_head_s),
      .empty     (ic_empty_s),
      .full      (ic_full_s),
      .overflow  (ic_ovf_s)
   );

   req_fifo #(.DEPTH(QDEPTH), .T(dc_entry_t)) u_dc_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.dc_req_ren | bus.dc_req_wen),
      .push_data (dc_push_s),
      .pop       (pop_dc_s),
      .head      (dc_head_s),
      .empty     (dc_empty_s),
      .full      (dc_full_s),
      .overflow  (dc_ovf_s)
   );

   // Grant decision, only taken while no transaction is in flight.
   always_comb begin
      grant_valid_s = (state_r == ARB_IDLE) && (!ic_empty_s || !dc_empty_s);
      grant_owner_s = next_owner(!ic_empty_s, !dc_empty_s, last_grant_r);
      pop_ic_s      = grant_valid_s && (grant_owner_s == OWNER_IC);
      pop_dc_s      = grant_valid_s && (grant_owner_s == OWNER_DC);
      rsp_match_s   = (state_r == ARB_WAIT) && bus.mem_rsp_valid &&
                      (bus.mem_rsp_addr == txn_addr_r);
   end

   // Transaction FSM with registered memory request outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= ARB_IDLE;
         owner_r         <= OWNER_IC;
         last_grant_r    <= OWNER_IC;
         mem_req_valid_r <= 1'b0;
         txn_wen_r       <= 1'b0;
         txn_addr_r      <= {PPTR_W{1'b0}};
         txn_line_r      <= {LINE_W{1'b0}};
      end else begin
         case (state_r)
            ARB_IDLE: begin
               if (grant_valid_s) begin
                  owner_r         <= grant_owner_s;
                  last_grant_r    <= grant_owner_s;
                  mem_req_valid_r <= 1'b1;
                  state_r         <= ARB_ISSUE;
                  if (grant_owner_s == OWNER_DC) begin
                     txn_wen_r  <= dc_head_s.wen;
                     txn_addr_r <= dc_head_s.addr;
                     txn_line_r <= dc_head_s.line;
                  end else begin
                     txn_wen_r  <= 1'b0;
                     txn_addr_r <= ic_head_s;
                     txn_line_r <= {LINE_W{1'b0}};
                  end
               end
            end
            ARB_ISSUE: begin
               if (bus.mem_req_ready) begin
                  mem_req_valid_r <= 1'b0;
                  state_r         <= txn_wen_r ? ARB_IDLE : ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (rsp_match_s) begin
                  state_r <= ARB_IDLE;
               end
            end
            default: begin
               state_r         <= ARB_IDLE;
               mem_req_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Refill delivery is combinational so the owner sees it in the response cycle.
   always_comb begin
      bus.ic_rec_en        = 1'b0;
      bus.ic_rec_addr      = {PPTR_W{1'b0}};
      bus.ic_rec_cacheline = {LINE_W{1'b0}};
      bus.dc_rec_en        = 1'b0;
      bus.dc_rec_addr      = {PPTR_W{1'b0}};
      bus.dc_rec_cacheline = {LINE_W{1'b0}};
      if (rsp_match_s && (owner_r == OWNER_IC)) begin
         bus.ic_rec_en        = 1'b1;
         bus.ic_rec_addr      = bus.mem_rsp_addr;
         bus.ic_rec_cacheline = bus.mem_rsp_cacheline;
      end else if (rsp_match_s) begin
         bus.dc_rec_en        = 1'b1;
         bus.dc_rec_addr      = bus.mem_rsp_addr;
         bus.dc_rec_cacheline = bus.mem_rsp_cacheline;
      end else begin
         bus.ic_rec_en = 1'b0;
      end
   end

   assign bus.mem_req_valid     = mem_req_valid_r;
   assign bus.mem_req_wen       = txn_wen_r;
   assign bus.mem_req_addr      = txn_addr_r;
   assign bus.mem_req_cacheline = txn_line_r;
   assign bus.ic_overflow       = ic_ovf_s;
   assign bus.dc_overflow       = dc_ovf_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory requests and refills are
// queued as stimulus is driven and retired as the DUT produces them.
module tb_mem_arbiter;
   import common::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus_if();

   mem_arbiter #(.QDEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic       wen;
      pptr_t      addr;
      cacheline_t line;
   } mreq_t;

   typedef struct {
      pptr_t addr;
      int    due;
   } pend_t;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         rsp_delay = 3;
   mreq_t      mem_exp_q [$];
   pptr_t      ic_rec_q [$];
   pptr_t      dc_rec_q [$];
   pend_t      pend_q [$];
   pend_t      rsp_p;
   mreq_t      mon_e;
   pptr_t      mon_a;
   cacheline_t wb_line;
   cacheline_t zero_line;

   function automatic cacheline_t line_of(input pptr_t a);
      cacheline_t l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = a ^ (32'h5A00_0000 + 32'(i));
      return l;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Memory model: one response per read, with wrong-address noise while waiting.
   initial begin
      bus_if.mem_rsp_valid     = 1'b0;
      bus_if.mem_rsp_addr      = 32'h0;
      bus_if.mem_rsp_cacheline = zero_line;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            rsp_p = pend_q.pop_front();
            bus_if.mem_rsp_valid     = 1'b1;
            bus_if.mem_rsp_addr      = rsp_p.addr;
            bus_if.mem_rsp_cacheline = line_of(rsp_p.addr);
         end else if (pend_q.size() > 0) begin
            bus_if.mem_rsp_valid     = 1'b1;
            bus_if.mem_rsp_addr      = pend_q[0].addr ^ 32'h40;
            bus_if.mem_rsp_cacheline = line_of(pend_q[0].addr ^ 32'h40);
         end else begin
            bus_if.mem_rsp_valid     = 1'b0;
            bus_if.mem_rsp_addr      = 32'h0;
            bus_if.mem_rsp_cacheline = zero_line;
         end
      end
   end

   // Monitor: retire expectations on memory handshakes and refill deliveries.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus_if.mem_req_valid && bus_if.mem_req_ready) begin
               if (mem_exp_q.size() == 0) begin
                  chk("mem_req_unexpected", 512'(mem_exp_q.size()), 512'(1));
               end else begin
                  mon_e = mem_exp_q.pop_front();
                  chk("mem_req_wen",  512'(bus_if.mem_req_wen),  512'(mon_e.wen));
                  chk("mem_req_addr", 512'(bus_if.mem_req_addr), 512'(mon_e.addr));
                  chk("mem_req_line", bus_if.mem_req_cacheline, mon_e.line);
                  if (!mon_e.wen) pend_q.push_back('{addr: mon_e.addr, due: cyc + rsp_delay});
               end
            end
            if (bus_if.ic_rec_en) begin
               if (ic_rec_q.size() == 0) begin
                  chk("ic_rec_unexpected", 512'(bus_if.ic_rec_addr), 512'(32'hFFFF_FFFF));
               end else begin
                  mon_a = ic_rec_q.pop_front();
                  chk("ic_rec_addr", 512'(bus_if.ic_rec_addr), 512'(mon_a));
                  chk("ic_rec_line", bus_if.ic_rec_cacheline, line_of(mon_a));
               end
            end
            if (bus_if.dc_rec_en) begin
               if (dc_rec_q.size() == 0) begin
                  chk("dc_rec_unexpected", 512'(bus_if.dc_rec_addr), 512'(32'hFFFF_FFFF));
               end else begin
                  mon_a = dc_rec_q.pop_front();
                  chk("dc_rec_addr", 512'(bus_if.dc_rec_addr), 512'(mon_a));
                  chk("dc_rec_line", bus_if.dc_rec_cacheline, line_of(mon_a));
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"},  512'(bus_if.mem_req_valid), 512'(0));
      chk({tag, "_rec_en"}, 512'({bus_if.ic_rec_en, bus_if.dc_rec_en}), 512'(0));
      chk({tag, "_ovf"},    512'({bus_if.ic_overflow, bus_if.dc_overflow}), 512'(0));
      chk({tag, "_addr"},   512'({bus_if.mem_req_wen, bus_if.mem_req_addr,
                                  bus_if.ic_rec_addr, bus_if.dc_rec_addr}), 512'(0));
      chk({tag, "_line"},   bus_if.mem_req_cacheline | bus_if.ic_rec_cacheline |
                            bus_if.dc_rec_cacheline, 512'(0));
   endtask

   task automatic do_reset(input bit clr_pend);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus_if.ic_req_ren = 1'b0;
      bus_if.dc_req_ren = 1'b0;
      bus_if.dc_req_wen = 1'b0;
      mem_exp_q.delete();
      ic_rec_q.delete();
      dc_rec_q.delete();
      if (clr_pend) pend_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic pulse(input logic ic, input logic dcr, input logic dcw,
                        input pptr_t ia, input pptr_t da, input cacheline_t dl);
      @(posedge clk);
      #1;
      bus_if.ic_req_ren       = ic;
      bus_if.ic_req_addr      = ia;
      bus_if.dc_req_ren       = dcr;
      bus_if.dc_req_wen       = dcw;
      bus_if.dc_req_addr      = da;
      bus_if.dc_req_cacheline = dl;
      @(posedge clk);
      #1;
      bus_if.ic_req_ren = 1'b0;
      bus_if.dc_req_ren = 1'b0;
      bus_if.dc_req_wen = 1'b0;
   endtask

   task automatic expect_rd(input arb_owner_t who, input pptr_t a);
      mem_exp_q.push_back('{wen: 1'b0, addr: a, line: zero_line});
      if (who == OWNER_IC) ic_rec_q.push_back(a);
      else                 dc_rec_q.push_back(a);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((mem_exp_q.size() + ic_rec_q.size() + dc_rec_q.size() + pend_q.size()) != 0
             && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", 512'(mem_exp_q.size() + ic_rec_q.size() + dc_rec_q.size()), 512'(0));
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      zero_line = {LINE_W{1'b0}};
      wb_line   = {16{32'hDEAD_0300}};
      bus_if.ic_req_ren       = 1'b0;
      bus_if.ic_req_addr      = 32'h0;
      bus_if.dc_req_ren       = 1'b0;
      bus_if.dc_req_wen       = 1'b0;
      bus_if.dc_req_addr      = 32'h0;
      bus_if.dc_req_cacheline = zero_line;
      bus_if.mem_req_ready    = 1'b1;

      // Single icache read: latency to mem_req_valid and refill routing.
      do_reset(1'b1);
      expect_rd(OWNER_IC, 32'h1000);
      @(posedge clk);
      #1;
      bus_if.ic_req_ren  = 1'b1;
      bus_if.ic_req_addr = 32'h1000;
      @(negedge clk);
      chk("lat_pulse_cycle", 512'(bus_if.mem_req_valid), 512'(0));
      @(posedge clk);
      #1;
      bus_if.ic_req_ren = 1'b0;
      @(negedge clk);
      chk("lat_grant_cycle", 512'(bus_if.mem_req_valid), 512'(0));
      @(negedge clk);
      chk("lat_issue", 512'({bus_if.mem_req_valid, bus_if.mem_req_addr}), 512'({1'b1, 32'h1000}));
      drain(50);

      // Simultaneous requests after reset: dcache wins first.
      do_reset(1'b1);
      expect_rd(OWNER_DC, 32'h200);
      expect_rd(OWNER_IC, 32'h100);
      pulse(1'b1, 1'b1, 1'b0, 32'h100, 32'h200, zero_line);
      drain(50);

      // Writeback then read of the same line stays in order; no refill for the write.
      mem_exp_q.push_back('{wen: 1'b1, addr: 32'h300, line: wb_line});
      expect_rd(OWNER_DC, 32'h300);
      pulse(1'b0, 1'b0, 1'b1, 32'h0, 32'h300, wb_line);
      pulse(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, zero_line);
      drain(50);

      // Stalled memory: request held stable for 10 cycles.
      bus_if.mem_req_ready = 1'b0;
      expect_rd(OWNER_IC, 32'h700);
      pulse(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, zero_line);
      n = 0;
      while (!bus_if.mem_req_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_hold", 512'({bus_if.mem_req_valid, bus_if.mem_req_wen, bus_if.mem_req_addr}),
             512'({1'b1, 1'b0, 32'h700}));
         chk("stall_line", bus_if.mem_req_cacheline, zero_line);
      end
      @(posedge clk);
      #1;
      bus_if.mem_req_ready = 1'b1;
      drain(50);

      // Overflow: FSM held busy by a dcache read, five icache pulses into depth 4.
      do_reset(1'b1);
      bus_if.mem_req_ready = 1'b0;
      expect_rd(OWNER_DC, 32'h500);
      pulse(1'b0, 1'b1, 1'b0, 32'h0, 32'h500, zero_line);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) expect_rd(OWNER_IC, 32'h800 + 32'(i * 64));
         pulse(1'b1, 1'b0, 1'b0, 32'h800 + 32'(i * 64), 32'h0, zero_line);
      end
      @(negedge clk);
      chk("ovf_set", 512'({bus_if.ic_overflow, bus_if.dc_overflow}), 512'({1'b1, 1'b0}));
      @(posedge clk);
      #1;
      bus_if.mem_req_ready = 1'b1;
      drain(100);
      chk("ovf_sticky", 512'({bus_if.ic_overflow, bus_if.dc_overflow}), 512'({1'b1, 1'b0}));

      // Reset while waiting for a read; the response arrives one cycle after reset.
      do_reset(1'b1);
      rsp_delay = 2;
      expect_rd(OWNER_IC, 32'h900);
      pulse(1'b1, 1'b0, 1'b0, 32'h900, 32'h0, zero_line);
      n = 0;
      while (!(bus_if.mem_req_valid && bus_if.mem_req_ready) && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      ic_rec_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wait_rsp_seen", 512'({bus_if.mem_rsp_valid, bus_if.mem_rsp_addr}),
          512'({1'b1, 32'h900}));
      check_reset_outputs("rst_wait");
      repeat (3) @(posedge clk);
      rsp_delay = 3;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter QDEPTH, default 4: entries per requester queue, power of two, >= 2.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ic_req_ren  input  1  icache line-read request pulse, one cycle per request, no backpressure.
REQ-005 ic_req_addr  input  pptr_t  line-aligned icache request address.
REQ-006 dc_req_ren / dc_req_wen  input  1 each  dcache read / writeback pulse; never both high in one cycle.
REQ-007 dc_req_addr  input  pptr_t; dc_req_cacheline  input  cacheline_t  writeback data.
REQ-008 ic_rec_en, ic_rec_addr, ic_rec_cacheline  output  1 / pptr_t / cacheline_t  icache refill delivery.
REQ-009 dc_rec_en, dc_rec_addr, dc_rec_cacheline  output  1 / pptr_t / cacheline_t  dcache refill delivery.
REQ-010 mem_req_valid / mem_req_ready  output / input  1  memory request handshake.
REQ-011 mem_req_wen  output  1; mem_req_addr  output  pptr_t; mem_req_cacheline  output  cacheline_t.
REQ-012 mem_rsp_valid  input  1; mem_rsp_addr  input  pptr_t; mem_rsp_cacheline  input  cacheline_t  read response.
REQ-013 ic_overflow / dc_overflow  output  1  sticky: request pulse arrived while queue full.

Function
REQ-014 Two FIFOs, icache (addr) and dcache (wen, addr, data); push on request pulse, QDEPTH entries, pointers wrap modulo QDEPTH, count width clog2(QDEPTH)+1.
REQ-015 Push to full queue: request dropped, matching overflow flag set, held until rst.
REQ-016 Push and pop same cycle on full queue: pop first, push accepted, no overflow.
REQ-017 FSM states IDLE, ISSUE, WAIT; one memory transaction outstanding at most.
REQ-018 IDLE: if a queue non-empty, grant round-robin (alternate from last_grant, reset value icache-last so dcache first), pop head into transaction register, record owner, -> ISSUE next cycle.
REQ-019 ISSUE: mem_req_valid=1 with registered wen/addr/data stable until mem_req_ready; on handshake write -> IDLE, read -> WAIT.
REQ-020 WAIT: on mem_rsp_valid with mem_rsp_addr equal to transaction addr, drive owner's rec_en=1, rec_addr, rec_cacheline combinationally same cycle, -> IDLE; non-matching responses ignored.
REQ-021 rec_en of non-owner stays 0; rec_en high exactly one cycle per read.
REQ-022 Duplicate addresses from both requesters are independent transactions; no merging.
REQ-023 Dcache queue order preserved: writeback followed by read of same line issues in order.
REQ-024 Minimum latency push-to-mem_req_valid: 2 cycles with empty queues in IDLE (push cycle, grant cycle).
REQ-025 Request pulses in any state are enqueued; FSM state never blocks pushes.

Reset
REQ-026 On rst: FIFOs empty, FSM IDLE, last_grant=icache, overflow flags 0, mem_req_valid 0, ic_rec_en 0, dc_rec_en 0; data/address outputs 0.
REQ-027 rst mid-transaction (ISSUE or WAIT) abandons it; later mem_rsp_valid ignored until a new read reaches WAIT.
REQ-028 Pulses coinciding with rst are discarded.

Structure
REQ-029 pptr_t, cacheline_t, byte_offset_t from package common; new arb_owner_t enum (OWNER_IC, OWNER_DC) and arb_state_t enum added to common.
REQ-030 One sub-module, req_fifo, parameterised by depth and payload type, instantiated twice.

Verification
REQ-031 ic_req_ren addr 0x1000, mem_req_ready=1, response 3 cycles after handshake -> mem_req_valid 2 cycles after pulse; ic_rec_en one cycle with addr 0x1000 and data.
REQ-032 ic and dc read pulses same cycle after reset (0x100, 0x200) -> dcache issued first, then icache; each rec routed to its owner only.
REQ-033 Five icache pulses, QDEPTH=4, mem_req_ready=0 -> four queued, ic_overflow=1 and stays 1; four responses later delivered in order.
REQ-034 dc writeback 0x300 then dc read 0x300 -> mem_req_wen=1 handshake first, no dc_rec_en for write, then read issued.
REQ-035 rst asserted in WAIT, response arrives next cycle -> no rec_en, all outputs at reset values.
REQ-036 mem_req_ready held 0 for 10 cycles in ISSUE -> mem_req_valid, addr, data stable all 10 cycles.
